// File: rtl/mux_4to1.sv
// Registered 4-to-1 multiplexer with a valid flag and one cycle of latency.
// Define MUX_4TO1_COMB_BYPASS_EN for a purely combinational, zero-latency variant.
module mux_4to1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [1:0]       sel_s;
    logic [WIDTH-1:0] pick_s;

    assign sel_s = {s1, s0};

    // Four-way pick; an unknown select lands in default and yields all-X in simulation
    always_comb begin
        pick_s = {WIDTH{1'b0}};
        case (sel_s)
            2'b00:   pick_s = w;
            2'b01:   pick_s = x;
            2'b10:   pick_s = y;
            2'b11:   pick_s = z;
            default: pick_s = {WIDTH{1'bx}};
        endcase
    end

`ifdef MUX_4TO1_COMB_BYPASS_EN
    assign out       = pick_s;
    assign out_valid = in_valid;
`else
    logic [WIDTH-1:0] out_r;
    logic             valid_r;

    // Output register: capture on in_valid, otherwise hold data and drop valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            valid_r <= in_valid;
            if (in_valid) begin
                out_r <= pick_s;
            end
        end
    end

    assign out       = out_r;
    assign out_valid = valid_r;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: a WIDTH=1 instance for the exhaustive sweep
// and a WIDTH=8 instance for table-driven wide-data, hold and reset sequences.
module tb_mux_4to1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       v1, s0_1, s1_1;
    logic [0:0] w1, x1, y1, z1, out1;
    logic       ov1;

    logic       v8, s0_8, s1_8;
    logic [7:0] w8, x8, y8, z8, out8;
    logic       ov8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1),
        .w(w1), .x(x1), .y(y1), .z(z1), .s0(s0_1), .s1(s1_1),
        .out(out1), .out_valid(ov1)
    );

    mux_4to1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8),
        .w(w8), .x(x8), .y(y8), .z(z8), .s0(s0_8), .s1(s1_8),
        .out(out8), .out_valid(ov8)
    );

    typedef struct {
        logic       vld;
        logic [1:0] sel;
        logic [7:0] w, x, y, z;
        logic [7:0] exp_out;
        logic       exp_vld;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive8(input logic vld, input logic [1:0] sel,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        v8 = vld; s1_8 = sel[1]; s0_8 = sel[0];
        w8 = a; x8 = b; y8 = c; z8 = d;
    endtask

    initial begin
        logic [5:0] iv;
        logic [1:0] sel;

        // hold/data-change cases rely on the previous row's captured value
        vecs[0] = '{1'b1, 2'b00, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'hA5, 1'b1};
        vecs[1] = '{1'b1, 2'b01, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h3C, 1'b1};
        vecs[2] = '{1'b1, 2'b10, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'hF0, 1'b1};
        vecs[3] = '{1'b1, 2'b11, 8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h0F, 1'b1};
        vecs[4] = '{1'b1, 2'b10, 8'hA5, 8'h3C, 8'h55, 8'h0F, 8'h55, 1'b1};
        vecs[5] = '{1'b0, 2'b10, 8'hA5, 8'h3C, 8'hAA, 8'h0F, 8'h55, 1'b0};
        vecs[6] = '{1'b0, 2'b00, 8'h11, 8'h3C, 8'hAA, 8'h0F, 8'h55, 1'b0};
        vecs[7] = '{1'b1, 2'b01, 8'h11, 8'hC3, 8'hAA, 8'h0F, 8'hC3, 1'b1};
        vecs[8] = '{1'b1, 2'b11, 8'h11, 8'h00, 8'hAA, 8'h7E, 8'h7E, 1'b1};

        v1 = 1'b1; s1_1 = 1'b1; s0_1 = 1'b1;
        w1 = 1'b1; x1 = 1'b1; y1 = 1'b1; z1 = 1'b1;
        drive8(1'b1, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

`ifdef MUX_4TO1_COMB_BYPASS_EN
        rst_n = 1'b0;
        drive8(1'b1, 2'b00, 8'h00, 8'h3C, 8'hF0, 8'h01);
        #1;
        chk("byp_sel00", out8, 8'h00);
        chk("byp_valid", {7'd0, ov8}, 8'h01);
        s1_8 = 1'b1; s0_8 = 1'b1;
        #1;
        chk("byp_sel11", out8, 8'h01);
        s1_8 = 1'b1; s0_8 = 1'b0;
        #1;
        chk("byp_sel10", out8, 8'hF0);
        v8 = 1'b0;
        #1;
        chk("byp_novalid", {7'd0, ov8}, 8'h00);
        for (int i = 0; i < 64; i++) begin
            iv = i[5:0];
            {s1_1, s0_1, w1, x1, y1, z1} = iv;
            sel = iv[5:4];
            #1;
            chk("byp_sweep", {7'd0, out1}, {7'd0, iv[3 - sel]});
        end
`else
        // Reset asserted between edges with all inputs high and valid
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out8_async", out8, 8'h00);
        chk("rst_vld8_async", {7'd0, ov8}, 8'h00);
        chk("rst_out1_async", {7'd0, out1}, 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_out8_edge", out8, 8'h00);
            chk("rst_vld8_edge", {7'd0, ov8}, 8'h00);
            chk("rst_out1_edge", {7'd0, out1}, 8'h00);
            chk("rst_vld1_edge", {7'd0, ov1}, 8'h00);
        end
        @(negedge clk);
        drive8(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;

        // Exhaustive WIDTH=1 sweep, back-to-back valid
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            iv = i[5:0];
            v1 = 1'b1;
            {s1_1, s0_1, w1, x1, y1, z1} = iv;
            sel = iv[5:4];
            @(posedge clk); #1;
            chk("sweep_out", {7'd0, out1}, {7'd0, iv[3 - sel]});
            chk("sweep_vld", {7'd0, ov1}, 8'h01);
        end
        @(negedge clk);
        v1 = 1'b0;
        @(posedge clk); #1;
        chk("w1_vld_drop", {7'd0, ov1}, 8'h00);

        // Table-driven WIDTH=8 vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive8(vecs[i].vld, vecs[i].sel, vecs[i].w, vecs[i].x, vecs[i].y, vecs[i].z);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out", i), out8, vecs[i].exp_out);
            chk($sformatf("vec%0d_vld", i), {7'd0, ov8}, {7'd0, vecs[i].exp_vld});
        end

        // Reset dropped between edges while a new selection is pending
        @(negedge clk);
        drive8(1'b1, 2'b10, 8'h00, 8'h00, 8'h5A, 8'h00);
        @(posedge clk); #1;
        chk("mid_pre_out", out8, 8'h5A);
        drive8(1'b1, 2'b00, 8'h33, 8'h00, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out8, 8'h00);
        chk("mid_rst_vld", {7'd0, ov8}, 8'h00);
        @(posedge clk); #1;
        chk("mid_hold_out", out8, 8'h00);
        chk("mid_hold_vld", {7'd0, ov8}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive8(1'b1, 2'b01, 8'h00, 8'h9C, 8'h00, 8'h00);
        #1;
        chk("rel_pre_out", out8, 8'h00);
        chk("rel_pre_vld", {7'd0, ov8}, 8'h00);
        @(posedge clk); #1;
        chk("rel_first_out", out8, 8'h9C);
        chk("rel_first_vld", {7'd0, ov8}, 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
- Registered 4-to-1 multiplexer.
- Selects one of four WIDTH-bit data inputs (w, x, y, z) using the two select bits {s1, s0}.
- The selected word is presented on out one clock later, with an accompanying valid flag.
- Used as a generic datapath selection leaf anywhere a registered 4-way pick is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of out; legal range is 1 or more.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies w/x/y/z/s1/s0 in the current cycle.
- w  input  WIDTH  data input 0, selected when {s1,s0}=2'b00.
- x  input  WIDTH  data input 1, selected when {s1,s0}=2'b01.
- y  input  WIDTH  data input 2, selected when {s1,s0}=2'b10.
- z  input  WIDTH  data input 3, selected when {s1,s0}=2'b11.
- s0  input  1  select LSB.
- s1  input  1  select MSB.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  high for one cycle per accepted in_valid.

Behaviour:
- Reset: rst_n low asynchronously forces out=0 and out_valid=0, regardless of clk. Both hold at 0 while rst_n is low.
- First update after reset is the first rising clk edge at which rst_n is high.
- Select mapping, sel = {s1,s0}:
  - 00 -> w
  - 01 -> x
  - 10 -> y
  - 11 -> z
  - s1 is the MSB. There are no other cases.
- Capture on a rising edge with in_valid=1:
  - out <= selected input, full WIDTH, no truncation or extension.
  - out_valid <= 1.
- Rising edge with in_valid=0:
  - out holds its previous value.
  - out_valid <= 0.
- Latency is exactly 1 cycle from sampled inputs to out/out_valid. Throughput is one selection per cycle; back-to-back in_valid is supported with no bubbles.
- Select and data are sampled on the same edge. Changing select and data in the same cycle yields the new data on the new select path; there is no mixing from the previous cycle.
- Unknown handling: if s1 or s0 is X/Z while in_valid=1, out becomes all-X in simulation. Synthesis treats this as don't-care.
- Reset asserted mid-stream: out and out_valid clear immediately. The selection in flight is discarded and never presented.
- No backpressure: the consumer must accept out whenever out_valid=1.

Optional Feature:
- Macro: MUX_4TO1_COMB_BYPASS_EN.
- Defined:
  - out = selected input combinationally, with zero latency, and follows w/x/y/z/s1/s0 continuously.
  - out_valid = in_valid combinationally.
  - clk and rst_n are ignored by the datapath; reset does not force out.
  - Port list is unchanged.
- Not defined: the registered behaviour above, with 1-cycle latency and async reset clearing.

Test Plan:
- Reset check: rst_n=0 with w=1, x=1, y=1, z=1, sel=11, in_valid=1 -> out=0 and out_valid=0 for every cycle rst_n stays low, including between clock edges.
- Exhaustive sweep, WIDTH=1: apply i=0..63 as {s1,s0,w,x,y,z}=i[5:0], in_valid=1, one per cycle. Required out one cycle later:
  - sel 00 -> w
  - sel 01 -> x
  - sel 10 -> y
  - sel 11 -> z
  - Example i=6'b10_0010 -> out=1; i=6'b11_1110 -> out=0.
- Wide data, WIDTH=8: w=8'hA5, x=8'h3C, y=8'hF0, z=8'h0F; sel 00, 01, 10, 11 on consecutive cycles -> out = A5, 3C, F0, 0F on the following cycles, with out_valid=1 throughout.
- Hold: capture sel=10 with y=8'h55, then in_valid=0 while y changes to 8'hAA -> out stays 8'h55 and out_valid=0.
- Async reset mid-stream: stream valid selections, then drop rst_n between edges -> out=0 and out_valid=0 immediately; after release, the first valid sample appears 1 cycle later.
- Bypass build (MUX_4TO1_COMB_BYPASS_EN): toggle sel 00->11 with w=0, z=1 and no clock edge -> out goes 0->1 within the same timestep.
